// File: rtl/conv_enc_frame_if.sv
// Handshake/bus bundle for conv_enc_frame: message input side and encoded symbol output side.
interface conv_enc_frame_if #(
  parameter int N     = 2,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             Ux;
  logic             out_valid;
  logic [N-1:0]     Vx;
  logic             sof;
  logic             tb_en;
  logic [CNT_W-1:0] blk_cnt;

  modport master (
    output in_valid, Ux,
    input  in_ready, out_valid, Vx, sof, tb_en, blk_cnt
  );
  modport slave (
    input  in_valid, Ux,
    output in_ready, out_valid, Vx, sof, tb_en, blk_cnt
  );
endinterface

// File: rtl/conv_enc_frame.sv
// Rate-1/N, constraint-length-K convolutional encoder with K-1 zero-tail block framing.
// Optional ERR_INJ_EN adds an err_mask port that XORs deterministic bit errors into Vx.
module conv_enc_frame #(
  parameter int               N         = 2,
  parameter int               K         = 3,
  parameter logic [N*K-1:0]   GEN       = 6'b101_111,
  parameter int               BLOCK_LEN = 20,
  parameter int               CNT_W     = 16
) (
  input  logic          clock,
  input  logic          reset,
`ifdef ERR_INJ_EN
  input  logic [N-1:0]  err_mask,
`endif
  conv_enc_frame_if.slave bus
);
  localparam int BW = $clog2(BLOCK_LEN) + 1;
  localparam int TW = $clog2(K) + 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(BLOCK_LEN - 1);
  localparam logic [TW-1:0] LAST_TAIL = TW'(K - 2);

  typedef enum logic {DATA, TAIL} state_t;

  state_t           state, state_n;
  logic [K-2:0]     sr;
  logic [BW-1:0]    bit_cnt;
  logic [TW-1:0]    tail_cnt;
  logic [CNT_W-1:0] blk_cnt;
  logic [N-1:0]     vx_q, vx_next, vx_load;
  logic             out_valid_q, sof_q, tb_en_q;

  logic       accept, tail_step, step, u, last_bit, last_tail;
  logic [K-1:0] w;

  always_ff @(posedge clock) begin
    if (!reset) state <= DATA;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    accept    = bus.in_valid && (state == DATA);
    tail_step = (state == TAIL);
    step      = accept || tail_step;
    u         = (state == DATA) ? bus.Ux : 1'b0;
    last_bit  = (bit_cnt == LAST_BIT);
    last_tail = (tail_cnt == LAST_TAIL);
    case (state)
      DATA:    if (accept && last_bit) state_n = TAIL;
      TAIL:    if (last_tail)          state_n = DATA;
      default: state_n = DATA;
    endcase
  end

  assign w = {u, sr};

  // One parity tree per generator polynomial
  for (genvar j = 0; j < N; j++) begin : g_gen
    assign vx_next[j] = ^(GEN[j*K +: K] & w);
  end

`ifdef ERR_INJ_EN
  assign vx_load = vx_next ^ err_mask;
`else
  assign vx_load = vx_next;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      sr          <= '0;
      bit_cnt     <= '0;
      tail_cnt    <= '0;
      blk_cnt     <= '0;
      vx_q        <= '0;
      out_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      tb_en_q     <= 1'b0;
    end else begin
      out_valid_q <= step;
      sof_q       <= accept && (bit_cnt == '0);
      tb_en_q     <= tail_step && last_tail;
      if (step) begin
        vx_q <= vx_load;
        sr   <= w[K-1:1];
      end
      if (accept) bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
      if (tail_step) begin
        tail_cnt <= last_tail ? '0 : tail_cnt + TW'(1);
        if (last_tail) blk_cnt <= blk_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = (state == DATA);
  assign bus.out_valid = out_valid_q;
  assign bus.Vx        = vx_q;
  assign bus.sof       = sof_q;
  assign bus.tb_en     = tb_en_q;
  assign bus.blk_cnt   = blk_cnt;
endmodule
